// File: rtl/data_ram_pkg.sv
package data_ram_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/data_ram_core.sv
module data_ram_core
  import data_ram_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned D_BITS   = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned RDW_MODE = RDW_READ_FIRST
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [D_BITS-1:0]     wr_data,
  input  logic [D_BITS/8-1:0]   wr_be,
  input  logic [ADDR_W-1:0]     a_addr,
  output logic [D_BITS-1:0]     a_rdata,
  input  logic [ADDR_W-1:0]     b_addr,
  output logic [D_BITS-1:0]     b_rdata
);

  localparam int unsigned       BE_W    = D_BITS / 8;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [D_BITS-1:0] mem [DEPTH];
  logic [D_BITS-1:0] merged;
  logic              wr_ok;
  logic              a_in, b_in;

  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_L);
  assign a_in  = {1'b0, a_addr} < DEPTH_L;
  assign b_in  = {1'b0, b_addr} < DEPTH_L;

  always_comb begin
    merged = mem[wr_addr];
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (wr_be[i]) begin
        merged[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= merged;
    end
  end

  // Write-first mode forwards the merged word when a read hits the word being written.
  always_comb begin
    a_rdata = '0;
    b_rdata = '0;
    if (a_in) begin
      a_rdata = (RDW_MODE == RDW_WRITE_FIRST && wr_ok && wr_addr == a_addr) ? merged : mem[a_addr];
    end
    if (b_in) begin
      b_rdata = (RDW_MODE == RDW_WRITE_FIRST && wr_ok && wr_addr == b_addr) ? merged : mem[b_addr];
    end
  end

endmodule

// File: rtl/data_ram.sv
module data_ram
  import data_ram_pkg::*;
#(
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned D_BITS         = 32,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned RDW_MODE       = RDW_READ_FIRST,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  output logic                busy,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [D_BITS-1:0]   a_din,
  input  logic [D_BITS/8-1:0] a_be,
  output logic                a_ready,
  output logic                a_rvalid,
  output logic [D_BITS-1:0]   a_dout,
  input  logic                b_req,
  input  logic [ADDR_W-1:0]   b_addr,
  output logic                b_ready,
  output logic                b_rvalid,
  output logic [D_BITS-1:0]   b_dout
);

  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
  localparam state_e            RESET_ST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                a_rvalid_q, a_rvalid_d;
  logic                b_rvalid_q, b_rvalid_d;
  logic [D_BITS-1:0]   a_dout_q, a_dout_d;
  logic [D_BITS-1:0]   b_dout_q, b_dout_d;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [D_BITS-1:0]   wr_data;
  logic [D_BITS/8-1:0] wr_be;
  logic [D_BITS-1:0]   a_rdata, b_rdata;

  assign busy     = (state_q == ST_CLEAR);
  assign a_ready  = !busy;
  assign b_ready  = !busy;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_dout   = a_dout_q;
  assign b_dout   = b_dout_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (clear) begin
          cnt_d = '0;
        end else if (cnt_q == LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    wr_en   = a_req && a_we;
    wr_addr = a_addr;
    wr_data = a_din;
    wr_be   = a_be;
    if (busy) begin
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_data = '0;
      wr_be   = '1;
    end
  end

  always_comb begin
    a_rvalid_d = a_req && a_ready && !a_we;
    b_rvalid_d = b_req && b_ready;
    a_dout_d   = a_rvalid_d ? a_rdata : a_dout_q;
    b_dout_d   = b_rvalid_d ? b_rdata : b_dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET_ST;
      cnt_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_dout_q   <= '0;
      b_dout_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_dout_q   <= a_dout_d;
      b_dout_q   <= b_dout_d;
    end
  end

  data_ram_core #(
    .DEPTH    (DEPTH),
    .D_BITS   (D_BITS),
    .ADDR_W   (ADDR_W),
    .RDW_MODE (RDW_MODE)
  ) u_core (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .a_addr  (a_addr),
    .a_rdata (a_rdata),
    .b_addr  (b_addr),
    .b_rdata (b_rdata)
  );

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter DEPTH, default 1024, number of words.
REQ-002 Parameter D_BITS, default 32, word width; SHALL be a multiple of 8.
REQ-003 Parameter ADDR_W, default 10, address width; DEPTH SHALL be at most 2**ADDR_W.
REQ-004 Parameter RDW_MODE, default 0, read-during-write to the same address: 0 = old data (read-first), 1 = new data (write-first).
REQ-005 Parameter CLEAR_ON_RESET, default 1, zero-fill the memory after reset when 1.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 clear  input  1  request a zero-fill of the whole memory.
REQ-009 busy  output  1  zero-fill in progress.
REQ-010 a_req, a_we  input  1 each  port A request; write when a_we=1, else read.
REQ-011 a_addr  input  ADDR_W  port A word address.
REQ-012 a_din  input  D_BITS  port A write data.
REQ-013 a_be  input  D_BITS/8  port A byte enables, bit i covers bits [8i+7:8i].
REQ-014 a_ready  output  1  port A accepts requests.
REQ-015 a_rvalid  output  1  a_dout carries read data.
REQ-016 a_dout  output  D_BITS  port A read data.
REQ-017 b_req  input  1  port B read request (read-only port).
REQ-018 b_addr  input  ADDR_W  port B word address.
REQ-019 b_ready, b_rvalid  output  1 each  port B accept and read-valid flags.
REQ-020 b_dout  output  D_BITS  port B read data.

Function
REQ-021 A request on either port SHALL be accepted in a cycle where req and ready are both 1; requests with ready=0 are ignored, not queued.
REQ-022 An accepted write SHALL update only the bytes whose a_be bit is 1; a_be=0 makes it a no-op that is still accepted.
REQ-023 An accepted read SHALL raise rvalid on the following cycle for exactly one cycle; dout SHALL hold its value until the next read completes.
REQ-024 Writes SHALL never raise a_rvalid.
REQ-025 A write to address X concurrent with a read of X on either port SHALL return pre-write data when RDW_MODE=0, and the merged post-write word when RDW_MODE=1.
REQ-026 Addresses >= DEPTH SHALL ignore writes and return all-zero read data with normal rvalid timing.
REQ-027 State machine: RUN and CLEAR; CLEAR writes zero to words 0..DEPTH-1, one per cycle, then enters RUN.
REQ-028 During CLEAR, busy=1 and a_ready=b_ready=0; in RUN, busy=0 and a_ready=b_ready=1.
REQ-029 clear=1 in RUN SHALL enter CLEAR on the next cycle; clear during CLEAR SHALL restart the counter at 0.
REQ-030 A zero-fill SHALL take exactly DEPTH cycles of busy=1 when not restarted.
REQ-031 Memory content SHALL be undefined after reset when CLEAR_ON_RESET=0.

Reset
REQ-032 While rst_n=0: a_rvalid=b_rvalid=0 and a_dout=b_dout=0.
REQ-033 While rst_n=0: busy=CLEAR_ON_RESET and a_ready=b_ready=!CLEAR_ON_RESET.
REQ-034 Reset exit SHALL enter CLEAR at word 0 when CLEAR_ON_RESET=1, else RUN.
REQ-035 Reset asserted mid-CLEAR or mid-read SHALL abort it and drop any pending rvalid.
REQ-036 Memory array content SHALL NOT be reset except through CLEAR.

Structure
REQ-037 A shared package SHALL hold the RUN/CLEAR state encoding and RDW_MODE constants (RDW_READ_FIRST=0, RDW_WRITE_FIRST=1).
REQ-038 The storage array plus byte-masked write SHALL sit in one sub-module, data_ram_core; data_ram adds the FSM, handshake, and output registers.

Verification
REQ-039 CLEAR_ON_RESET=1, DEPTH=16: release rst_n -> busy=1 for exactly 16 cycles, then read of addr 5 returns 0.
REQ-040 Write 0xAABBCCDD to addr 3, then write 0x11223344 with a_be=4'b0101 -> read returns 0xAA22CC44 one cycle after acceptance.
REQ-041 RDW_MODE=0: addr 7 holds 0x1; A writes 0x2 while B reads 7 -> b_dout=0x1. With RDW_MODE=1 -> b_dout=0x2.
REQ-042 DEPTH=12, ADDR_W=4: write 0xFF to addr 13, then read 13 -> rvalid=1, dout=0; addr 0..11 unchanged.
REQ-043 Pulse clear at count 4 of an in-progress CLEAR (DEPTH=16) -> busy stays high for 16 more cycles; requests with ready=0 give no rvalid.
REQ-044 Assert rst_n=0 the cycle after a read is accepted -> a_rvalid never rises, a_dout=0.
